// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction fetch sequencer.
//
// Owns the fetch PC, issues word reads to instruction memory over a
// request/response port, and buffers returned words in a small in-order
// queue for decode. A redirect flushes the queue, reloads the PC and
// discards any responses still in flight for the old path.
//
// Ports:
//   clk, rst           core clock, asynchronous active-high reset
//   fetch_en           allow new requests (in-flight requests still complete)
//   imem_req_*         read request (valid/ready/addr), word-aligned address
//   imem_resp_*        in-order read response, no backpressure
//   redirect_valid/pc  single-cycle redirect to a new PC
//   instr_valid/ready  queue head handshake towards decode
//   instr_data/pc      head instruction word and its PC
//   stall_cycles       perf counter of running cycles with nothing for decode
//
// Build option: define FETCH_PERF_EN to build the stall_cycles counter;
// otherwise stall_cycles is tied to zero.

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic [31:0] stall_cycles
);

  localparam int AW = $clog2(BUF_DEPTH);
  // One extra bit so counters can hold the value BUF_DEPTH itself.
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_next;

  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic [31:0]   q_data [BUF_DEPTH];
  logic [31:0]   q_pc   [BUF_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] drop_load;
  logic          req_fire, push, pop;
  logic          unused_bits;

  // Low PC bits from a redirect are ignored; the stored PC is word-aligned.
  assign unused_bits = ^redirect_pc[1:0];

  // Everything still in flight on a redirect belongs to the old path; a
  // response landing in the redirect cycle is discarded directly, so it is
  // not counted again.
  assign drop_load = outstanding - CW'(imem_resp_valid);

  assign req_fire = imem_req_valid && imem_req_ready;
  assign push     = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;
  assign pop      = instr_valid && instr_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      if (drop_load != '0) begin
        state_next = FLUSH;
      end else begin
        state_next = fetch_en ? RUN : IDLE;
      end
    end else begin
      case (state)
        IDLE:    if (fetch_en) state_next = RUN;
        RUN:     if (!fetch_en && (outstanding == '0)) state_next = IDLE;
        FLUSH:   if (imem_resp_valid && (drop_cnt == ONE_C)) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  // Credit rule: queued plus in-flight words never exceed the queue size,
  // so every response always has a free slot.
  always_comb begin
    imem_req_valid = 1'b0;
    instr_valid    = 1'b0;
    if ((state == RUN) && fetch_en && !redirect_valid &&
        ((count + outstanding) < DEPTH_C)) begin
      imem_req_valid = 1'b1;
    end
    if ((count != '0) && !redirect_valid) begin
      instr_valid = 1'b1;
    end
  end

  assign imem_req_addr = {pc[31:2], 2'b00};
  assign instr_data    = q_data[rd_ptr];
  assign instr_pc      = q_pc[rd_ptr];

  // ---------------- PC, counters, queue pointers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
      if (redirect_valid) begin
        pc       <= {redirect_pc[31:2], 2'b00};
        resp_pc  <= {redirect_pc[31:2], 2'b00};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        drop_cnt <= drop_load;
      end else begin
        if (req_fire) begin
          pc <= pc + 32'd4;
        end
        if (imem_resp_valid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - ONE_C;
        end
        if (push) begin
          wr_ptr  <= wr_ptr + 1'b1;
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // ---------------- Queue storage ----------------
  // Cleared on reset so the head reads as zero until the first word lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (push) begin
      q_data[wr_ptr] <= imem_resp_data;
      q_pc[wr_ptr]   <= resp_pc;
    end
  end

  // ---------------- Optional stall counter ----------------
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == RUN) && fetch_en && !instr_valid &&
                 (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = 32'h0000_0000;
`endif

`ifndef SYNTHESIS
  // A response can only answer a request that was actually accepted.
  resp_needs_request: assert property (
    @(posedge clk) disable iff (rst) imem_resp_valid |-> (outstanding != '0));
`endif

endmodule
